// File: rtl/k005297_pgmatch.sv
// Relative-page capture and page search for the K005297 bubble controller.
// Assembles the serial page number once per rotation and hunts for a target page.
module k005297_pgmatch #(
  parameter int PAGES    = 2053,
  parameter int TO_PAGES = 2053
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_RELPGCNTR_LSB,
  input  logic        i_SRCH_START,
  input  logic        i_SRCH_ABORT,
  input  logic [11:0] i_TARGET_PG,
  output logic [11:0] o_PAGE,
  output logic        o_PAGE_VLD,
  output logic        o_RELPGCNTR_CNT_START,
  output logic        o_RELPGCNTR_CNT_STOP,
  output logic        o_BUSY,
  output logic        o_SRCH_HIT,
  output logic        o_SRCH_ERR
);

  typedef enum logic [2:0] {IDLE, ARMED, SEARCH, HIT, ERR} state_t;

  localparam logic [12:0] PAGES_LIM = 13'(PAGES);
  localparam logic [11:0] TO_LIM    = 12'(TO_PAGES);

  logic        en;
  logic [19:0] slot_low;
  logic        slot_valid;
  logic [4:0]  slot_idx;
  logic        slot_zero;
  logic        commit;
  logic        frame_ok;
  logic [11:0] capture;

  state_t      state, state_nx;
  logic [11:0] target, target_nx;
  logic [11:0] cnt, cnt_nx, cnt_inc;
  logic        busy_nx, hit_nx, err_nx, start_nx, stop_nx;

  assign en = ~i_CLK2M_PCEN_n;

  // A slot is valid only when exactly one rotation line is low.
  always_comb begin
    slot_low   = ~i_ROT20_n;
    slot_valid = (slot_low != 20'd0) && ((slot_low & (slot_low - 20'd1)) == 20'd0);
    slot_idx   = 5'd0;
    for (int i = 0; i < 20; i++)
      if (slot_low[i]) slot_idx = 5'(i);
  end

  assign slot_zero = slot_valid && (slot_idx == 5'd0);
  // frame_ok blocks a commit of a partial frame seen right after reset.
  assign commit    = slot_valid && (slot_idx == 5'd12) && frame_ok;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      capture    <= 12'd0;
      o_PAGE     <= 12'd0;
      o_PAGE_VLD <= 1'b0;
      frame_ok   <= 1'b0;
    end else if (en) begin
      o_PAGE_VLD <= commit;
      if (slot_zero) frame_ok <= 1'b1;
      if (commit) o_PAGE <= capture;
      for (int k = 0; k < 12; k++)
        if (slot_valid && slot_idx == 5'(k)) capture[k] <= i_RELPGCNTR_LSB;
    end
  end

  assign cnt_inc = (cnt == TO_LIM) ? cnt : cnt + 12'd1;

  always_comb begin
    state_nx  = state;
    target_nx = target;
    cnt_nx    = cnt;
    busy_nx   = o_BUSY;
    hit_nx    = o_SRCH_HIT;
    err_nx    = o_SRCH_ERR;
    start_nx  = 1'b0;
    stop_nx   = 1'b0;
    case (state)
      IDLE, HIT, ERR: begin
        if (i_SRCH_ABORT) begin
          state_nx = IDLE;
          hit_nx   = 1'b0;
          err_nx   = 1'b0;
        end else if (i_SRCH_START) begin
          target_nx = i_TARGET_PG;
          hit_nx    = 1'b0;
          err_nx    = 1'b0;
          if ({1'b0, i_TARGET_PG} >= PAGES_LIM) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end else begin
            state_nx = ARMED;
            busy_nx  = 1'b1;
            start_nx = 1'b1;
          end
        end
      end
      ARMED: begin
        if (i_SRCH_ABORT) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          stop_nx  = 1'b1;
        end else if (slot_zero) begin
          state_nx = SEARCH;
          cnt_nx   = 12'd0;
        end
      end
      SEARCH: begin
        if (i_SRCH_ABORT) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          stop_nx  = 1'b1;
        end else if (commit) begin
          cnt_nx = cnt_inc;
          // A match on the timeout commit still counts as a hit.
          if (capture == target) begin
            state_nx = HIT;
            hit_nx   = 1'b1;
            busy_nx  = 1'b0;
            stop_nx  = 1'b1;
          end else if (cnt_inc == TO_LIM) begin
            state_nx = ERR;
            err_nx   = 1'b1;
            busy_nx  = 1'b0;
            stop_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state                 <= IDLE;
      target                <= 12'd0;
      cnt                   <= 12'd0;
      o_BUSY                <= 1'b0;
      o_SRCH_HIT            <= 1'b0;
      o_SRCH_ERR            <= 1'b0;
      o_RELPGCNTR_CNT_START <= 1'b0;
      o_RELPGCNTR_CNT_STOP  <= 1'b0;
    end else if (en) begin
      state                 <= state_nx;
      target                <= target_nx;
      cnt                   <= cnt_nx;
      o_BUSY                <= busy_nx;
      o_SRCH_HIT            <= hit_nx;
      o_SRCH_ERR            <= err_nx;
      o_RELPGCNTR_CNT_START <= start_nx;
      o_RELPGCNTR_CNT_STOP  <= stop_nx;
    end
  end

endmodule
